// File: rtl/freq_meter_pkg.sv
// ============================================================================
// Module   : freq_meter_pkg
// Brief    : Shared types and defaults for the frequency-meter pulse-train generator.
// Revision : 1.0
// ============================================================================
`default_nettype none

package freq_meter_pkg;

  localparam int CNT_W_DEF = 32;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    HIGH = 2'd1,
    LOW  = 2'd2
  } ptg_state_t;

endpackage

`default_nettype wire

// File: rtl/pulse_train_gen_phase_timer.sv
// ============================================================================
// Module   : phase_timer
// Brief    : Loadable down-counter; expire marks the last cycle of the loaded count.
// Revision : 1.0
// ============================================================================
`default_nettype none

module phase_timer
  import freq_meter_pkg::*;
#(
  parameter int CNT_W = CNT_W_DEF
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic [CNT_W-1:0] load_val,
  input  logic             en,
  output logic             expire
);

  logic [CNT_W-1:0] r_count;

  always_ff @(posedge clk) begin
    if (!rst) begin
      r_count <= '0;
    end else if (load) begin
      r_count <= load_val;
    end else if (en && (r_count != '0)) begin
      r_count <= r_count - CNT_W'(1);
    end
  end

  assign expire = (r_count == CNT_W'(1));

endmodule

`default_nettype wire

// File: rtl/pulse_train_gen.sv
// ============================================================================
// Module   : pulse_train_gen
// Brief    : Programmable HIGH/LOW pulse-train source, finite burst or continuous.
// Revision : 1.0
// ============================================================================
`default_nettype none

module pulse_train_gen
  import freq_meter_pkg::*;
#(
  parameter int CNT_W = CNT_W_DEF
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             enable,
  input  logic             start,
  input  logic             stop,
  input  logic [CNT_W-1:0] high_cycles,
  input  logic [CNT_W-1:0] low_cycles,
  input  logic [CNT_W-1:0] burst_len,
  output logic             pulse_out,
  output logic             busy,
  output logic             done,
  output logic [CNT_W-1:0] pulse_count
);

  ptg_state_t       r_state;
  logic [CNT_W-1:0] r_high_cfg;
  logic [CNT_W-1:0] r_low_cfg;
  logic [CNT_W-1:0] r_burst_cfg;

  logic             w_tmr_load;
  logic [CNT_W-1:0] w_tmr_val;
  logic             w_tmr_expire;
  logic [CNT_W-1:0] w_high_eff;
  logic [CNT_W-1:0] w_low_eff;
  logic             w_start_ok;
  logic             w_phase_end;
  logic             w_more;

  // Zero-length phases are stretched to one cycle when latched.
  assign w_high_eff  = (high_cycles == '0) ? CNT_W'(1) : high_cycles;
  assign w_low_eff   = (low_cycles == '0) ? CNT_W'(1) : low_cycles;
  assign w_start_ok  = (r_state == IDLE) && start && !stop && enable;
  assign w_phase_end = enable && !stop && w_tmr_expire;
  assign w_more      = (r_burst_cfg == '0) || (pulse_count < r_burst_cfg);

  always_comb begin
    w_tmr_load = 1'b0;
    w_tmr_val  = w_high_eff;
    case (r_state)
      IDLE: begin
        if (w_start_ok) begin
          w_tmr_load = 1'b1;
          w_tmr_val  = w_high_eff;
        end
      end
      HIGH: begin
        if (w_phase_end) begin
          w_tmr_load = 1'b1;
          w_tmr_val  = r_low_cfg;
        end
      end
      LOW: begin
        if (w_phase_end && w_more) begin
          w_tmr_load = 1'b1;
          w_tmr_val  = r_high_cfg;
        end
      end
      default: begin
        w_tmr_load = 1'b0;
      end
    endcase
  end

  phase_timer #(
    .CNT_W(CNT_W)
  ) u_phase_timer (
    .clk     (clk),
    .rst     (rst),
    .load    (w_tmr_load),
    .load_val(w_tmr_val),
    .en      (enable),
    .expire  (w_tmr_expire)
  );

  always_ff @(posedge clk) begin
    if (!rst) begin
      r_state     <= IDLE;
      r_high_cfg  <= '0;
      r_low_cfg   <= '0;
      r_burst_cfg <= '0;
      pulse_out   <= 1'b0;
      busy        <= 1'b0;
      done        <= 1'b0;
      pulse_count <= '0;
    end else begin
      done <= 1'b0;
      if (stop) begin
        r_state   <= IDLE;
        pulse_out <= 1'b0;
        busy      <= 1'b0;
      end else begin
        case (r_state)
          IDLE: begin
            if (w_start_ok) begin
              r_high_cfg  <= w_high_eff;
              r_low_cfg   <= w_low_eff;
              r_burst_cfg <= burst_len;
              r_state     <= HIGH;
              pulse_out   <= 1'b1;
              busy        <= 1'b1;
              pulse_count <= CNT_W'(1);
            end
          end
          HIGH: begin
            if (w_phase_end) begin
              r_state   <= LOW;
              pulse_out <= 1'b0;
            end
          end
          LOW: begin
            if (w_phase_end) begin
              if (w_more) begin
                r_state     <= HIGH;
                pulse_out   <= 1'b1;
                pulse_count <= pulse_count + CNT_W'(1);
              end else begin
                r_state <= IDLE;
                busy    <= 1'b0;
                done    <= 1'b1;
              end
            end
          end
          default: begin
            r_state   <= IDLE;
            pulse_out <= 1'b0;
            busy      <= 1'b0;
          end
        endcase
      end
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_pulse_train_gen.sv
// ============================================================================
// Module   : tb_pulse_train_gen
// Brief    : Scoreboard bench for pulse_train_gen; expected cycles queued per stimulus.
// Revision : 1.0
// ============================================================================
`default_nettype none

module tb_pulse_train_gen;

  localparam int W = 32;

  logic         clk = 1'b0;
  logic         rst;
  logic         enable;
  logic         start;
  logic         stop;
  logic [W-1:0] high_cycles;
  logic [W-1:0] low_cycles;
  logic [W-1:0] burst_len;
  logic         pulse_out;
  logic         busy;
  logic         done;
  logic [W-1:0] pulse_count;

  typedef struct packed {
    logic         po;
    logic         bsy;
    logic         dn;
    logic [W-1:0] cnt;
  } exp_t;

  exp_t exp_q[$];
  int   tests_run    = 0;
  int   tests_failed = 0;
  int   rises        = 0;
  logic prev_po      = 1'b0;

  pulse_train_gen #(.CNT_W(W)) dut (
    .clk        (clk),
    .rst        (rst),
    .enable     (enable),
    .start      (start),
    .stop       (stop),
    .high_cycles(high_cycles),
    .low_cycles (low_cycles),
    .burst_len  (burst_len),
    .pulse_out  (pulse_out),
    .busy       (busy),
    .done       (done),
    .pulse_count(pulse_count)
  );

  always #5 clk = ~clk;

  task automatic push_exp(input logic po, input logic bsy, input logic dn, input logic [W-1:0] cnt);
    exp_t e;
    e.po  = po;
    e.bsy = bsy;
    e.dn  = dn;
    e.cnt = cnt;
    exp_q.push_back(e);
  endtask

  // Ideal waveform of a finite burst followed by the done cycle.
  task automatic push_burst(input int h, input int l, input int n);
    int he;
    int le;
    he = (h == 0) ? 1 : h;
    le = (l == 0) ? 1 : l;
    for (int p = 1; p <= n; p++) begin
      for (int i = 0; i < he; i++) push_exp(1'b1, 1'b1, 1'b0, W'(p));
      for (int i = 0; i < le; i++) push_exp(1'b0, 1'b1, 1'b0, W'(p));
    end
    push_exp(1'b0, 1'b0, 1'b1, W'(n));
  endtask

  task automatic step(input string tag);
    exp_t e;
    @(posedge clk);
    #1;
    if (pulse_out === 1'b1 && prev_po === 1'b0) rises++;
    prev_po = pulse_out;
    tests_run++;
    if (exp_q.size() == 0) begin
      tests_failed++;
      $display("FAIL %s: scoreboard empty, observed po=%0b busy=%0b done=%0b count=%0d",
               tag, pulse_out, busy, done, pulse_count);
    end else begin
      e = exp_q.pop_front();
      if ({pulse_out, busy, done, pulse_count} !== e) begin
        tests_failed++;
        $display("FAIL %s @%0t: observed po=%0b busy=%0b done=%0b count=%0d, expected po=%0b busy=%0b done=%0b count=%0d",
                 tag, $time, pulse_out, busy, done, pulse_count, e.po, e.bsy, e.dn, e.cnt);
      end
    end
  endtask

  task automatic run_queue(input string tag);
    int budget;
    budget = 5000;
    while (exp_q.size() != 0 && budget > 0) begin
      step(tag);
      budget--;
    end
  endtask

  task automatic test_reset();
    rst = 1'b0; enable = 1'b1; start = 1'b0; stop = 1'b0;
    high_cycles = '0; low_cycles = '0; burst_len = '0;
    repeat (2) @(posedge clk);
    #1;
    tests_run++;
    if (pulse_out !== 1'b0) begin tests_failed++; $display("FAIL reset_pulse_out: observed %0b expected 0", pulse_out); end
    tests_run++;
    if (busy !== 1'b0) begin tests_failed++; $display("FAIL reset_busy: observed %0b expected 0", busy); end
    tests_run++;
    if (done !== 1'b0) begin tests_failed++; $display("FAIL reset_done: observed %0b expected 0", done); end
    tests_run++;
    if (pulse_count !== '0) begin tests_failed++; $display("FAIL reset_count: observed %0d expected 0", pulse_count); end
    rst = 1'b1;
    prev_po = 1'b0;
  endtask

  task automatic test_burst();
    high_cycles = 4; low_cycles = 3; burst_len = 15;
    push_burst(4, 3, 15);
    push_exp(1'b0, 1'b0, 1'b0, W'(15));
    rises = 0;
    start = 1'b1;
    step("burst");
    start = 1'b0;
    repeat (3) step("burst");
    high_cycles = 9; low_cycles = 1; burst_len = 2;
    run_queue("burst");
    tests_run++;
    if (rises !== 15) begin
      tests_failed++;
      $display("FAIL burst_edges: observed %0d rising edges, expected 15", rises);
    end
  endtask

  task automatic test_min_phase();
    high_cycles = 0; low_cycles = 0; burst_len = 3;
    push_burst(0, 0, 3);
    push_exp(1'b0, 1'b0, 1'b0, W'(3));
    start = 1'b1;
    step("min_phase");
    start = 1'b0;
    run_queue("min_phase");
  endtask

  task automatic test_continuous_stop();
    high_cycles = 6; low_cycles = 10; burst_len = 0;
    for (int c = 0; c <= 40; c++)
      push_exp(((c % 16) < 6) ? 1'b1 : 1'b0, 1'b1, 1'b0, W'(c / 16 + 1));
    start = 1'b1;
    step("continuous");
    start = 1'b0;
    repeat (40) step("continuous");
    stop = 1'b1;
    push_exp(1'b0, 1'b0, 1'b0, W'(3));
    step("stop_idle");
    stop = 1'b0;
    push_exp(1'b0, 1'b0, 1'b0, W'(3));
    step("stop_hold");
  endtask

  task automatic test_pause();
    high_cycles = 4; low_cycles = 3; burst_len = 2;
    for (int i = 0; i < 7; i++) push_exp(1'b1, 1'b1, 1'b0, W'(1));
    for (int i = 0; i < 2; i++) push_exp(1'b1, 1'b1, 1'b0, W'(1));
    for (int i = 0; i < 3; i++) push_exp(1'b0, 1'b1, 1'b0, W'(1));
    for (int i = 0; i < 4; i++) push_exp(1'b1, 1'b1, 1'b0, W'(2));
    for (int i = 0; i < 3; i++) push_exp(1'b0, 1'b1, 1'b0, W'(2));
    push_exp(1'b0, 1'b0, 1'b1, W'(2));
    push_exp(1'b0, 1'b0, 1'b0, W'(2));
    start = 1'b1;
    step("pause");
    start = 1'b0;
    step("pause");
    enable = 1'b0;
    repeat (5) step("pause_frozen");
    enable = 1'b1;
    run_queue("pause");
  endtask

  task automatic test_start_busy();
    high_cycles = 2; low_cycles = 2; burst_len = 2;
    push_burst(2, 2, 2);
    push_exp(1'b0, 1'b0, 1'b0, W'(2));
    start = 1'b1;
    step("start_busy");
    start = 1'b0;
    step("start_busy");
    high_cycles = 7; start = 1'b1;
    step("start_busy");
    start = 1'b0;
    run_queue("start_busy");
    enable = 1'b0; start = 1'b1;
    push_exp(1'b0, 1'b0, 1'b0, W'(2));
    step("start_disabled");
    enable = 1'b1; start = 1'b0;
    push_exp(1'b0, 1'b0, 1'b0, W'(2));
    step("start_not_queued");
  endtask

  task automatic test_stop_priority();
    high_cycles = 3; low_cycles = 3; burst_len = 0;
    start = 1'b1; stop = 1'b1;
    push_exp(1'b0, 1'b0, 1'b0, W'(2));
    step("start_stop");
    start = 1'b0; stop = 1'b0;
    push_exp(1'b0, 1'b0, 1'b0, W'(2));
    step("start_stop_hold");
    start = 1'b1;
    push_exp(1'b1, 1'b1, 1'b0, W'(1));
    push_exp(1'b1, 1'b1, 1'b0, W'(1));
    step("stop_paused");
    start = 1'b0;
    step("stop_paused");
    enable = 1'b0; stop = 1'b1;
    push_exp(1'b0, 1'b0, 1'b0, W'(1));
    step("stop_over_pause");
    enable = 1'b1; stop = 1'b0;
    push_exp(1'b0, 1'b0, 1'b0, W'(1));
    step("stop_over_pause_hold");
  endtask

  task automatic test_reset_mid();
    high_cycles = 3; low_cycles = 5; burst_len = 4;
    for (int i = 0; i < 3; i++) push_exp(1'b1, 1'b1, 1'b0, W'(1));
    for (int i = 0; i < 2; i++) push_exp(1'b0, 1'b1, 1'b0, W'(1));
    start = 1'b1;
    step("reset_mid");
    start = 1'b0;
    repeat (4) step("reset_mid");
    rst = 1'b0;
    push_exp(1'b0, 1'b0, 1'b0, W'(0));
    step("reset_mid_values");
    rst = 1'b1;
    push_exp(1'b0, 1'b0, 1'b0, W'(0));
    step("reset_mid_no_done");
  endtask

  initial begin
    test_reset();
    test_burst();
    test_min_phase();
    test_continuous_stop();
    test_pause();
    test_start_busy();
    test_stop_priority();
    test_reset_mid();
    tests_run++;
    if (exp_q.size() != 0) begin
      tests_failed++;
      $display("FAIL scoreboard_drain: observed %0d entries left, expected 0", exp_q.size());
    end
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule

`default_nettype wire
